// File: rtl/video_wr_axi_master_pkg.sv
// Shared definitions for the video line write AXI master.
//   AXI_BURST_INCR / AXI_RESP_OKAY : AXI encodings used by the master.
//   wr_state_e                     : burst sequencer states.
//   calc_awsize                    : AWSIZE for a given data bus width.
package video_wr_axi_master_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

  // log2 of the bus width in bytes
  function automatic logic [2:0] calc_awsize(input int unsigned data_width);
    logic [2:0] sz;
    sz = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) == (data_width / 8)) sz = i[2:0];
    end
    return sz;
  endfunction

endpackage

// File: rtl/video_wr_axi_master_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_flush        : synchronous empty request, overrides push/pop
//   i_push, i_data : write side (ignored when full unless a pop frees a slot)
//   i_pop          : consume head (ignored when empty)
//   o_data         : current head word, valid whenever o_empty is low
//   o_full, o_empty, o_count : occupancy
module sync_fifo_fwft #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
  // a same-cycle pop frees the slot, so a push into a full FIFO is kept
  assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/video_wr_axi_master.sv
// Video line write AXI4 master: buffers packed line words and per-line
// commands, then issues one INCR write burst per line.
//   i_wr_buff_*        : line data words and line commands from the write controller
//   i_wr_buff_frame_reset : level flush request; in-flight burst completes with null beats
//   o_m_axi_aw* / w* / b* : AXI4 write channels
//   o_wr_busy          : burst in progress or command queued
//   o_wr_overflow      : sticky, a word or command was dropped on a full FIFO
//   o_wr_bresp_err     : sticky, a non-OKAY write response was seen
module video_wr_axi_master
  import video_wr_axi_master_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH  = 128,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned DATA_FIFO_DEPTH = 512,
  parameter int unsigned CMD_FIFO_DEPTH  = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_wr_buff_req_en,
  input  logic                        i_wr_buff_vld,
  input  logic [7:0]                  i_wr_buff_burst_len,
  input  logic [AXI_ADDR_WIDTH-1:0]   i_wr_buff_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   i_wr_buff_data,
  input  logic                        i_wr_buff_data_last,
  input  logic                        i_wr_buff_frame_reset,
  output logic [AXI_ADDR_WIDTH-1:0]   o_m_axi_awaddr,
  output logic [7:0]                  o_m_axi_awlen,
  output logic [2:0]                  o_m_axi_awsize,
  output logic [1:0]                  o_m_axi_awburst,
  output logic                        o_m_axi_awvalid,
  input  logic                        i_m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   o_m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] o_m_axi_wstrb,
  output logic                        o_m_axi_wlast,
  output logic                        o_m_axi_wvalid,
  input  logic                        i_m_axi_wready,
  input  logic [1:0]                  i_m_axi_bresp,
  input  logic                        i_m_axi_bvalid,
  output logic                        o_m_axi_bready,
  output logic                        o_wr_busy,
  output logic                        o_wr_overflow,
  output logic                        o_wr_bresp_err
);

  localparam int unsigned CMD_W  = AXI_ADDR_WIDTH + 8;
  localparam int unsigned DCNT_W = $clog2(DATA_FIFO_DEPTH + 1);
  localparam int unsigned CCNT_W = $clog2(CMD_FIFO_DEPTH + 1);
  localparam logic [2:0]  AWSIZE = calc_awsize(AXI_DATA_WIDTH);

  wr_state_e                 r_state;
  logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]                r_awlen;
  logic [7:0]                r_beat;
  logic                      r_flush;
  logic                      r_overflow;
  logic                      r_bresp_err;

  logic                      w_data_push, w_data_pop, w_data_full, w_data_empty;
  logic [AXI_DATA_WIDTH-1:0] w_data_head;
  logic [DCNT_W-1:0]         w_data_count;
  logic                      w_cmd_push, w_cmd_pop, w_cmd_full, w_cmd_empty;
  logic [CMD_W-1:0]          w_cmd_head;
  logic [CCNT_W-1:0]         w_cmd_count;
  logic                      w_in_w, w_zero_beat, w_wlast;
  logic                      w_data_drop, w_cmd_drop;
  logic                      w_unused;

  assign w_unused = &{1'b0, i_wr_buff_data_last, w_data_count, w_cmd_count};

  assign w_data_push = i_wr_buff_vld    & ~i_wr_buff_frame_reset;
  assign w_cmd_push  = i_wr_buff_req_en & ~i_wr_buff_frame_reset;
  // no pop while flushing, otherwise a command could be issued against flushed data
  assign w_cmd_pop   = (r_state == ST_IDLE) & ~w_cmd_empty & ~i_wr_buff_frame_reset;

  assign w_in_w      = (r_state == ST_W);
  // frame reset takes effect on the current beat, then latches until B completes
  assign w_zero_beat = r_flush | i_wr_buff_frame_reset;
  assign w_wlast     = w_in_w & (r_beat == r_awlen);
  assign w_data_pop  = w_in_w & i_m_axi_wready & ~w_zero_beat;

  assign w_data_drop = w_data_push & w_data_full & ~(w_data_pop & ~w_data_empty);
  assign w_cmd_drop  = w_cmd_push  & w_cmd_full  & ~w_cmd_pop;

  sync_fifo_fwft #(
    .WIDTH (AXI_DATA_WIDTH),
    .DEPTH (DATA_FIFO_DEPTH)
  ) u_data_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (i_wr_buff_frame_reset),
    .i_push  (w_data_push),
    .i_data  (i_wr_buff_data),
    .i_pop   (w_data_pop),
    .o_data  (w_data_head),
    .o_full  (w_data_full),
    .o_empty (w_data_empty),
    .o_count (w_data_count)
  );

  sync_fifo_fwft #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_flush (i_wr_buff_frame_reset),
    .i_push  (w_cmd_push),
    .i_data  ({i_wr_buff_addr, i_wr_buff_burst_len}),
    .i_pop   (w_cmd_pop),
    .o_data  (w_cmd_head),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty),
    .o_count (w_cmd_count)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_beat      <= '0;
      r_flush     <= 1'b0;
      r_overflow  <= 1'b0;
      r_bresp_err <= 1'b0;
    end else begin
      if (w_data_drop || w_cmd_drop) r_overflow <= 1'b1;
      if (i_wr_buff_frame_reset && (r_state == ST_AW || r_state == ST_W)) r_flush <= 1'b1;
      case (r_state)
        ST_IDLE: if (w_cmd_pop) begin
          r_awaddr <= w_cmd_head[CMD_W-1:8];
          r_awlen  <= w_cmd_head[7:0];
          r_state  <= ST_AW;
        end
        ST_AW: if (i_m_axi_awready) begin
          r_beat  <= '0;
          r_state <= ST_W;
        end
        ST_W: if (i_m_axi_wready) begin
          if (w_wlast) r_state <= ST_B;
          else         r_beat  <= r_beat + 1'b1;
        end
        ST_B: if (i_m_axi_bvalid) begin
          if (i_m_axi_bresp != AXI_RESP_OKAY) r_bresp_err <= 1'b1;
          r_flush <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_m_axi_awaddr  = r_awaddr;
  assign o_m_axi_awlen   = r_awlen;
  assign o_m_axi_awsize  = AWSIZE;
  assign o_m_axi_awburst = AXI_BURST_INCR;
  assign o_m_axi_awvalid = (r_state == ST_AW);
  assign o_m_axi_wvalid  = w_in_w;
  assign o_m_axi_wdata   = (w_in_w & ~w_zero_beat) ? w_data_head : '0;
  assign o_m_axi_wstrb   = (w_in_w & ~w_zero_beat) ? '1 : '0;
  assign o_m_axi_wlast   = w_wlast;
  assign o_m_axi_bready  = (r_state == ST_B);
  assign o_wr_busy       = (r_state != ST_IDLE) | ~w_cmd_empty;
  assign o_wr_overflow   = r_overflow;
  assign o_wr_bresp_err  = r_bresp_err;

endmodule

// File: tb/tb_video_wr_axi_master.sv
module tb_video_wr_axi_master;

  localparam int DW    = 128;
  localparam int AWD   = 32;
  localparam int LIMIT = 20000;

  typedef struct { logic [DW-1:0] data; logic [DW/8-1:0] strb; logic last; } beat_t;
  typedef struct { logic [AWD-1:0] addr; logic [7:0] len; } aw_t;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            i_wr_buff_req_en, i_wr_buff_vld, i_wr_buff_data_last, i_wr_buff_frame_reset;
  logic [7:0]      i_wr_buff_burst_len;
  logic [AWD-1:0]  i_wr_buff_addr;
  logic [DW-1:0]   i_wr_buff_data;
  logic [AWD-1:0]  o_m_axi_awaddr;
  logic [7:0]      o_m_axi_awlen;
  logic [2:0]      o_m_axi_awsize;
  logic [1:0]      o_m_axi_awburst;
  logic            o_m_axi_awvalid, i_m_axi_awready;
  logic [DW-1:0]   o_m_axi_wdata;
  logic [DW/8-1:0] o_m_axi_wstrb;
  logic            o_m_axi_wlast, o_m_axi_wvalid, i_m_axi_wready;
  logic [1:0]      i_m_axi_bresp;
  logic            i_m_axi_bvalid, o_m_axi_bready;
  logic            o_wr_busy, o_wr_overflow, o_wr_bresp_err;

  always #5 i_clk = ~i_clk;

  video_wr_axi_master #(
    .AXI_DATA_WIDTH  (DW),
    .AXI_ADDR_WIDTH  (AWD),
    .DATA_FIFO_DEPTH (512),
    .CMD_FIFO_DEPTH  (4)
  ) dut (
    .i_clk (i_clk), .i_reset (i_reset),
    .i_wr_buff_req_en (i_wr_buff_req_en), .i_wr_buff_vld (i_wr_buff_vld),
    .i_wr_buff_burst_len (i_wr_buff_burst_len), .i_wr_buff_addr (i_wr_buff_addr),
    .i_wr_buff_data (i_wr_buff_data), .i_wr_buff_data_last (i_wr_buff_data_last),
    .i_wr_buff_frame_reset (i_wr_buff_frame_reset),
    .o_m_axi_awaddr (o_m_axi_awaddr), .o_m_axi_awlen (o_m_axi_awlen),
    .o_m_axi_awsize (o_m_axi_awsize), .o_m_axi_awburst (o_m_axi_awburst),
    .o_m_axi_awvalid (o_m_axi_awvalid), .i_m_axi_awready (i_m_axi_awready),
    .o_m_axi_wdata (o_m_axi_wdata), .o_m_axi_wstrb (o_m_axi_wstrb),
    .o_m_axi_wlast (o_m_axi_wlast), .o_m_axi_wvalid (o_m_axi_wvalid),
    .i_m_axi_wready (i_m_axi_wready), .i_m_axi_bresp (i_m_axi_bresp),
    .i_m_axi_bvalid (i_m_axi_bvalid), .o_m_axi_bready (o_m_axi_bready),
    .o_wr_busy (o_wr_busy), .o_wr_overflow (o_wr_overflow), .o_wr_bresp_err (o_wr_bresp_err)
  );

  // reference model state
  beat_t         exp_w[$];
  aw_t           exp_aw[$];
  logic [DW-1:0] mdata[$];
  int checks = 0, failures = 0, cyc = 0;
  int dlevel = 0, lines_issued = 0, exp_b = 0;
  int aw_hs = 0, w_hs = 0, b_hs = 0, pend_b = 0, aw_wait = 0, aw_start_cyc = -1, req_cyc = 0;
  int rdy_mode = 0, aw_delay = 0;
  bit exp_ovf = 0, exp_err = 0, force_err = 0, b_acc = 0, aw_hold = 0, aw_seen = 0, tog = 0;
  bit w_stall_prev = 0;
  logic [DW-1:0] prev_wdata;
  logic          prev_wlast;
  aw_t           m_aw;
  beat_t         m_w;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor / scoreboard: samples on the falling edge, ahead of the next rising edge
  always @(negedge i_clk) begin
    if (!i_reset) begin
      if (o_m_axi_awvalid && !aw_seen) begin aw_seen = 1; aw_start_cyc = cyc; end
      if (o_m_axi_awvalid && i_m_axi_awready) begin
        aw_seen = 0; aw_wait = 0; aw_hs++;
        if (exp_aw.size() == 0) chk("aw_unexpected", 128'(1), 128'(0));
        else begin
          m_aw = exp_aw.pop_front();
          chk("awaddr", 128'(o_m_axi_awaddr), 128'(m_aw.addr));
          chk("awlen", 128'(o_m_axi_awlen), 128'(m_aw.len));
        end
        chk("awsize", 128'(o_m_axi_awsize), 128'(3'd4));
        chk("awburst", 128'(o_m_axi_awburst), 128'(2'b01));
      end else if (o_m_axi_awvalid) aw_wait++;
      if (o_m_axi_wvalid && w_stall_prev) begin
        chk("w_hold_data", o_m_axi_wdata, prev_wdata);
        chk("w_hold_last", 128'(o_m_axi_wlast), 128'(prev_wlast));
      end
      if (o_m_axi_wvalid && i_m_axi_wready) begin
        w_hs++;
        if (exp_w.size() == 0) chk("w_unexpected", 128'(1), 128'(0));
        else begin
          m_w = exp_w.pop_front();
          chk("wdata", o_m_axi_wdata, m_w.data);
          chk("wstrb", 128'(o_m_axi_wstrb), 128'(m_w.strb));
          chk("wlast", 128'(o_m_axi_wlast), 128'(m_w.last));
          if (m_w.strb != '0) dlevel--;
        end
        if (o_m_axi_wlast) pend_b++;
      end
      w_stall_prev = o_m_axi_wvalid && !i_m_axi_wready;
      prev_wdata   = o_m_axi_wdata;
      prev_wlast   = o_m_axi_wlast;
      if (i_m_axi_bvalid && o_m_axi_bready) begin b_acc = 1; b_hs++; end
    end
  end

  // AW / W ready driver
  initial begin
    i_m_axi_awready = 1'b0;
    i_m_axi_wready  = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      tog = ~tog;
      case (rdy_mode)
        0:       i_m_axi_wready = 1'b1;
        1:       i_m_axi_wready = 1'($urandom_range(0, 1));
        default: i_m_axi_wready = tog;
      endcase
      if (aw_hold)           i_m_axi_awready = 1'b0;
      else if (aw_delay > 0) i_m_axi_awready = (aw_wait >= aw_delay);
      else if (rdy_mode == 1) i_m_axi_awready = 1'($urandom_range(0, 1));
      else                   i_m_axi_awready = 1'b1;
    end
  end

  // B responder
  initial begin
    i_m_axi_bvalid = 1'b0;
    i_m_axi_bresp  = 2'b00;
    forever begin
      @(posedge i_clk); #1;
      if (i_m_axi_bvalid && b_acc) begin i_m_axi_bvalid = 1'b0; b_acc = 0; end
      if (!i_m_axi_bvalid && pend_b > 0 && $urandom_range(0, 1) == 1) begin
        pend_b--;
        i_m_axi_bvalid = 1'b1;
        i_m_axi_bresp  = force_err ? 2'b10 : 2'b00;
        force_err = 0;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  task automatic model_push(input logic [DW-1:0] d);
    if (dlevel >= 512) exp_ovf = 1;
    else begin mdata.push_back(d); dlevel++; end
  endtask

  // a line command takes len+1 of the oldest buffered words
  task automatic model_cmd(input logic [AWD-1:0] a, input logic [7:0] l);
    aw_t t;
    beat_t b;
    t.addr = a; t.len = l;
    exp_aw.push_back(t);
    exp_b++; lines_issued++;
    for (int i = 0; i <= int'(l); i++) begin
      if (mdata.size() > 0) b.data = mdata.pop_front();
      else b.data = '0;
      b.strb = '1;
      b.last = (i == int'(l));
      exp_w.push_back(b);
    end
  endtask

  task automatic drive_word(input logic [DW-1:0] d, input bit req, input logic [AWD-1:0] a, input logic [7:0] l);
    tick();
    i_wr_buff_vld = 1'b1; i_wr_buff_data = d;
    i_wr_buff_req_en = req; i_wr_buff_data_last = req;
    i_wr_buff_addr = a; i_wr_buff_burst_len = l;
    if (req) req_cyc = cyc;
    model_push(d);
    if (req) model_cmd(a, l);
  endtask

  task automatic drive_idle();
    tick();
    i_wr_buff_vld = 1'b0; i_wr_buff_req_en = 1'b0; i_wr_buff_data_last = 1'b0;
  endtask

  task automatic send_line(input logic [AWD-1:0] a, input logic [7:0] l, input logic [DW-1:0] base, input bit rnd);
    logic [DW-1:0] d;
    for (int i = 0; i <= int'(l); i++) begin
      d = rnd ? {$urandom(), $urandom(), $urandom(), $urandom()} : base + 128'(i);
      drive_word(d, i == int'(l), a, l);
    end
    drive_idle();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((exp_w.size() != 0 || exp_aw.size() != 0 || pend_b != 0 || i_m_axi_bvalid) && n < LIMIT) begin
      tick(); n++;
    end
    chk({tag, "_timeout"}, 128'(n >= LIMIT), 128'(0));
    repeat (3) tick();
    chk({tag, "_busy"}, 128'(o_wr_busy), 128'(0));
    chk({tag, "_bcount"}, 128'(b_hs), 128'(exp_b));
    chk({tag, "_overflow"}, 128'(o_wr_overflow), 128'(exp_ovf));
    chk({tag, "_bresp_err"}, 128'(o_wr_bresp_err), 128'(exp_err));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    beat_t keep[$];
    beat_t b;
    i_reset = 1'b1;
    i_wr_buff_req_en = 0; i_wr_buff_vld = 0; i_wr_buff_data_last = 0; i_wr_buff_frame_reset = 0;
    i_wr_buff_burst_len = '0; i_wr_buff_addr = '0; i_wr_buff_data = '0;
    repeat (4) tick();
    i_reset = 1'b0;
    tick();

    // reset state
    chk("rst_awvalid", 128'(o_m_axi_awvalid), 128'(0));
    chk("rst_wvalid", 128'(o_m_axi_wvalid), 128'(0));
    chk("rst_wlast", 128'(o_m_axi_wlast), 128'(0));
    chk("rst_wstrb", 128'(o_m_axi_wstrb), 128'(0));
    chk("rst_wdata", o_m_axi_wdata, 128'(0));
    chk("rst_bready", 128'(o_m_axi_bready), 128'(0));
    chk("rst_awaddr", 128'(o_m_axi_awaddr), 128'(0));
    chk("rst_awlen", 128'(o_m_axi_awlen), 128'(0));
    chk("rst_awsize", 128'(o_m_axi_awsize), 128'(4));
    chk("rst_awburst", 128'(o_m_axi_awburst), 128'(1));
    chk("rst_busy", 128'(o_wr_busy), 128'(0));
    chk("rst_overflow", 128'(o_wr_overflow), 128'(0));
    chk("rst_bresp_err", 128'(o_wr_bresp_err), 128'(0));

    // single line, data 0x1..0x8, AW two cycles after the command strobe
    rdy_mode = 0;
    send_line(32'h1000_0000, 8'd7, 128'h1, 0);
    wait_idle("single");
    chk("aw_latency", 128'(aw_start_cyc - req_cyc), 128'(2));

    // back-pressure on a 4-beat line
    rdy_mode = 2;
    base = w_hs;
    send_line(32'h1000_2000, 8'd3, 128'h11, 0);
    wait_idle("bp");
    chk("bp_handshakes", 128'(w_hs - base), 128'(4));

    // three queued lines with delayed awready
    rdy_mode = 0; aw_delay = 5;
    send_line(32'h0000_0000, 8'd15, 128'h100, 0);
    send_line(32'h0000_1000, 8'd15, 128'h200, 0);
    send_line(32'h0000_2000, 8'd15, 128'h300, 0);
    wait_idle("queued");
    aw_delay = 0;

    // error response followed by a normal line
    force_err = 1; exp_err = 1;
    send_line(32'h2000_0000, 8'd3, 128'hA00, 0);
    send_line(32'h2000_1000, 8'd3, 128'hB00, 0);
    wait_idle("bresp");

    // randomized lines with random ready behaviour
    rdy_mode = 1;
    for (int k = 0; k < 24; k++) begin
      n = 0;
      while (((lines_issued - aw_hs) >= 3 || dlevel > 400) && n < LIMIT) begin tick(); n++; end
      chk("rand_throttle_timeout", 128'(n >= LIMIT), 128'(0));
      send_line(32'($urandom()) & 32'hFFFF_F000, 8'($urandom_range(0, 31)), '0, 1);
    end
    wait_idle("random");

    // frame reset after beat 3 of a 16-beat burst, with a second line queued
    rdy_mode = 0; aw_hold = 1;
    send_line(32'h3000_0000, 8'd15, 128'h500, 0);
    send_line(32'h3000_1000, 8'd15, 128'h600, 0);
    base = w_hs; aw_hold = 0;
    n = 0;
    while (w_hs < base + 3 && n < 1000) begin tick(); n++; end
    chk("fr_wait_timeout", 128'(n >= 1000), 128'(0));
    i_wr_buff_frame_reset = 1'b1;
    keep.delete();
    while (exp_w.size() > 0) begin
      b = exp_w.pop_front();
      b.data = '0; b.strb = '0;
      keep.push_back(b);
      if (b.last) break;
    end
    exp_w = keep;
    exp_b -= exp_aw.size();
    exp_aw.delete(); mdata.delete(); dlevel = 0;
    repeat (3) tick();
    i_wr_buff_frame_reset = 1'b0;
    wait_idle("frame_reset");
    chk("fr_beats", 128'(w_hs - base), 128'(16));
    send_line(32'h3000_2000, 8'd3, 128'h700, 0);
    wait_idle("post_flush");

    // overflow: fill the data FIFO with the bus stalled, then one more word
    aw_hold = 1;
    for (int i = 0; i < 513; i++) drive_word(128'h8000 + 128'(i), 0, '0, '0);
    drive_idle();
    tick();
    chk("ovf_flag", 128'(o_wr_overflow), 128'(1));
    chk("ovf_model", 128'(exp_ovf), 128'(1));
    tick();
    i_wr_buff_req_en = 1'b1; i_wr_buff_addr = 32'h4000_0000; i_wr_buff_burst_len = 8'd255;
    model_cmd(32'h4000_0000, 8'd255);
    tick();
    i_wr_buff_addr = 32'h4000_1000;
    model_cmd(32'h4000_1000, 8'd255);
    tick();
    i_wr_buff_req_en = 1'b0;
    aw_hold = 0;
    wait_idle("overflow");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_wr_axi_master.md
Name: video_wr_axi_master

Overview:
- Downstream of the video write controller.
- Buffers packed line data (o_wr_buff_vld/data) and per-line write commands (req_en/addr/burst_len) from that controller.
- Issues one AXI4 INCR write burst per video line to DDR.
- Handles frame resets cleanly, without breaking AXI protocol.

Parameters:
- AXI_DATA_WIDTH, 128, width of line data words and of WDATA.
- AXI_ADDR_WIDTH, 32, width of AWADDR.
- DATA_FIFO_DEPTH, 512, data words buffered (at least 2 max-length lines).
- CMD_FIFO_DEPTH, 4, queued line commands.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous active-high reset.
- i_wr_buff_req_en  in  1  one-cycle line command strobe.
- i_wr_buff_vld  in  1  data word valid.
- i_wr_buff_burst_len  in  8  AWLEN for the line (beats-1).
- i_wr_buff_addr  in  AXI_ADDR_WIDTH  line start address, sampled with req_en.
- i_wr_buff_data  in  AXI_DATA_WIDTH  packed pixel word.
- i_wr_buff_data_last  in  1  last word of line (same cycle as req_en).
- i_wr_buff_frame_reset  in  1  level; flush request.
- o_m_axi_awaddr  out  AXI_ADDR_WIDTH; o_m_axi_awlen  out  8; o_m_axi_awsize  out  3; o_m_axi_awburst  out  2; o_m_axi_awvalid  out  1; i_m_axi_awready  in  1.
- o_m_axi_wdata  out  AXI_DATA_WIDTH; o_m_axi_wstrb  out  AXI_DATA_WIDTH/8; o_m_axi_wlast  out  1; o_m_axi_wvalid  out  1; i_m_axi_wready  in  1.
- i_m_axi_bresp  in  2; i_m_axi_bvalid  in  1; o_m_axi_bready  out  1.
- o_wr_busy  out  1  FSM not IDLE or cmd FIFO non-empty.
- o_wr_overflow  out  1  sticky: data or cmd pushed while full.
- o_wr_bresp_err  out  1  sticky: BRESP != OKAY.

Behaviour:
- Clock and reset: single clock i_clk; i_reset synchronous, active-high, used directly.
- Reset values: all outputs 0, except awsize = log2(AXI_DATA_WIDTH/8) and awburst = 2'b01 (both constant); both FIFOs empty; FSM in IDLE.
- Data push: every cycle i_wr_buff_vld=1 and i_wr_buff_frame_reset=0. If the data FIFO is full, the word is dropped and o_wr_overflow is set.
- Command push: every cycle i_wr_buff_req_en=1 and frame_reset=0 pushes {addr, burst_len}. If the cmd FIFO is full, the command is dropped and o_wr_overflow is set. A command is pushed only after all its data, so issuing it never underruns.
- FSM states: IDLE, AW, W, B.
- IDLE: on cmd FIFO non-empty, pop the command and latch addr/len. Go to AW; awvalid=1 in the next cycle. Cmd pushed at cycle N into an empty FIFO while IDLE gives awvalid high at N+2.
- AW: hold awaddr/awlen/awvalid stable until awready. On the handshake, deassert awvalid and go to W.
- W: wdata is driven from the data FIFO head (first-word-fall-through); wvalid=1; wstrb all ones.
  - Beat counter counts 0..len; wlast=1 when counter == len.
  - FIFO pops only on wvalid&wready.
  - After the wlast handshake go to B.
  - No bubble is required between beats while wready is high.
- B: bready=1. On bvalid, set o_wr_bresp_err if bresp != 0, then go to IDLE. The next AW may start the cycle after.
- Frame reset (level high, checked every cycle):
  - Both FIFOs are flushed (empty) and pushes are ignored.
  - If the FSM is in AW or W, the burst completes legally: AW proceeds unchanged.
  - Remaining W beats are driven with wdata=0, wstrb=0, keeping correct wlast. FIFO data is not used while in flush mode, and the flush mode latches until B completes.
  - In B, wait normally.
- Simultaneous events:
  - Data push and pop in the same cycle on a full FIFO: the pop frees the slot first, so no overflow.
  - Cmd push during IDLE pop: both are accepted.
- Address and length:
  - awaddr is passed through unchanged.
  - Lines longer than 256 beats are not supported; a len value of 8 bits wraps as given.
- Reset mid-burst: immediate return to IDLE, valids drop to 0. Accepted as a system-level protocol break, since DDR reset accompanies it.

Decomposition:
- Shared package holds: AXI_BURST_INCR=2'b01, AXI_RESP_OKAY=2'b00, FSM state encoding (IDLE/AW/W/B), and a function computing awsize from data width.
- One natural sub-module: sync_fifo_fwft. It is parameterised by width/depth, has full, empty and count outputs, and synchronous reset plus flush. It is instantiated twice: data FIFO (AXI_DATA_WIDTH wide) and cmd FIFO (AXI_ADDR_WIDTH+8 wide).

Test Plan:
- Single line: push 8 words (0x1..0x8), last word with req_en, addr=0x1000_0000, len=7, awready/wready always 1 -> awvalid at N+2, awaddr=0x1000_0000, awlen=7, 8 beats of data 0x1..0x8, wlast on beat 8, bready asserted, o_wr_busy returns to 0.
- Back-pressure: wready toggled 1,0,1,0 on a 4-beat line (len=3) -> data held stable while wready=0, exactly 4 handshakes, wlast only on the 4th.
- Queued lines: 3 lines pushed back to back (addr 0x0, 0x1000, 0x2000; len=15), awready delayed 5 cycles -> three bursts in order with correct addresses, no data interleave, o_wr_overflow=0.
- Frame reset mid-burst: assert frame_reset after beat 3 of a 16-beat burst -> beats 4..16 driven with wstrb=0; burst ends with wlast at beat 16; B accepted; both FIFOs empty; no new AW issued.
- Overflow: fill data FIFO to 512 with AXI stalled (awready=0), push one more word -> o_wr_overflow=1 and stays 1; FIFO count stays 512.
- Error response: bresp=2'b10 on a burst -> o_wr_bresp_err=1 sticky, FSM returns to IDLE and services the next command normally.
